// File: rtl/spi_byte_rx.sv
// SPI mode-0 slave receiver: pin synchronisers, byte assembly with D/C flag and
// optional MISO read-back serialiser (enabled by defining SPI_BYTE_RX_MISO_EN).
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       spi_sclk_i,
  input  logic       spi_mosi_i,
  input  logic       spi_cs_n_i,
  input  logic       spi_dc_i,
  input  logic [7:0] spi_tx_data_i,
  output logic       spi_miso_o,
  output logic       spi_byte_vld_o,
  output logic [7:0] spi_byte_data_o,
  output logic       dc_o
);

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_n_sync, dc_sync;
  logic                   sclk_s, mosi_s, cs_n_s, dc_s;
  logic                   sclk_d, cs_n_d;
  logic [SYNC_STAGES:0]   warm;
  logic                   idle_seen;
  logic                   armed;
  logic [2:0]             bit_cnt;
  logic [2:0]             cnt_eff;
  logic [7:0]             rx_shift;
  logic                   sclk_rise, sclk_fall, cs_fall, active;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_n_sync <= '1;
      dc_sync   <= '0;
      sclk_d    <= 1'b0;
      cs_n_d    <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], spi_cs_n_i};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi_dc_i};
      sclk_d    <= sclk_s;
      cs_n_d    <= cs_n_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_n_s = cs_n_sync[SYNC_STAGES-1];
  assign dc_s   = dc_sync[SYNC_STAGES-1];

  // The chain resets to cs_n=1, so a pin already low at reset release would look
  // like a chip-select fall; only trust cs_n after a real high has passed through.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      warm      <= '0;
      idle_seen <= 1'b0;
    end else begin
      warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
      idle_seen <= idle_seen | (warm[SYNC_STAGES] & cs_n_d);
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = idle_seen & cs_n_d & ~cs_n_s;
  assign active    = ~cs_n_s & (armed | cs_fall);
  assign cnt_eff   = cs_fall ? 3'd0 : bit_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      armed           <= 1'b0;
      bit_cnt         <= 3'd0;
      rx_shift        <= 8'h00;
      spi_byte_vld_o  <= 1'b0;
      spi_byte_data_o <= 8'h00;
      dc_o            <= 1'b0;
    end else begin
      if (cs_n_s) begin
        armed <= 1'b0;
      end else if (cs_fall) begin
        armed <= 1'b1;
      end

      if (!active) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        bit_cnt <= cnt_eff + 3'd1;
      end else if (cs_fall) begin
        bit_cnt <= 3'd0;
      end

      if (active && sclk_rise) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
      end

      spi_byte_vld_o <= active & sclk_rise & (cnt_eff == 3'd7);
      if (active && sclk_rise && (cnt_eff == 3'd7)) begin
        spi_byte_data_o <= {rx_shift[6:0], mosi_s};
        dc_o            <= dc_s;
      end
    end
  end

`ifdef SPI_BYTE_RX_MISO_EN
  logic [7:0] tx_shift;

  // Reload at every byte boundary so the next read-back byte starts on the
  // falling edge after the 8th rising edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_shift   <= 8'h00;
      spi_miso_o <= 1'b0;
    end else begin
      if (cs_fall) begin
        tx_shift <= spi_tx_data_i;
      end else if (active && sclk_fall) begin
        if (cnt_eff == 3'd0) begin
          tx_shift <= spi_tx_data_i;
        end else begin
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
      spi_miso_o <= active ? tx_shift[7] : 1'b0;
    end
  end
`else
  logic unused_tx;
  assign unused_tx  = ^{spi_tx_data_i, sclk_fall};
  assign spi_miso_o = 1'b0;
`endif

endmodule
